mem_port_arbiter: RTL and testbench

// - Shares the single memory port between instruction fetch (IFU) and load/store (LSU) requesters.
// - Serialises accesses with a req/gnt/rvalid handshake; drives mem_en/mem_wr/mem_addr/mem_size.
// - Sits between the decoder/control FSM and on-chip RAM, replacing the static mem_addr_sel address mux.

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IFU and LSU using a req/gnt/rvalid handshake.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LSU wins on simultaneous requests.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_gnt,
  output logic              ifu_rvalid,
  input  logic              lsu_req,
  input  logic              lsu_wr,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [2:0]        lsu_size,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [2:0] SIZE_WORD = 3'b010;
  localparam logic [2:0] LAT       = 3'(RD_LATENCY);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
      $error("mem_port_arbiter: RD_LATENCY must be in 1..7");
    end
  endgenerate

  state_e            state_q, state_d;
  logic              owner_lsu_q, owner_lsu_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [2:0]        size_q, size_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pick_lsu;

`ifdef MEM_ARB_RR_EN
  logic rr_last_lsu_q, rr_last_lsu_d;

  // rr_last follows the owner of every granted access
  always_comb begin
    rr_last_lsu_d = rr_last_lsu_q;
    if (state_q == ISSUE) begin
      rr_last_lsu_d = owner_lsu_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_lsu_q <= 1'b0;
    end else begin
      rr_last_lsu_q <= rr_last_lsu_d;
    end
  end

  always_comb begin
    pick_lsu = lsu_req && (!ifu_req || !rr_last_lsu_q);
  end
`else
  always_comb begin
    pick_lsu = lsu_req;
  end
`endif

  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    size_d      = size_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE, RESP: begin
        // requests are only sampled here; anything raised and dropped meanwhile is lost
        if (ifu_req || lsu_req) begin
          state_d     = ISSUE;
          owner_lsu_d = pick_lsu;
          if (pick_lsu) begin
            addr_d  = lsu_addr;
            wdata_d = lsu_wdata;
            wr_d    = lsu_wr;
            size_d  = lsu_size;
          end else begin
            addr_d = ifu_addr;
            wr_d   = 1'b0;
            size_d = SIZE_WORD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_lsu_q <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      size_q      <= SIZE_WORD;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_en     = (state_q == ISSUE);
  assign ifu_gnt    = (state_q == ISSUE) && !owner_lsu_q;
  assign lsu_gnt    = (state_q == ISSUE) && owner_lsu_q;
  assign ifu_rvalid = (state_q == RESP) && !owner_lsu_q;
  assign lsu_rvalid = (state_q == RESP) && owner_lsu_q;
  assign busy       = (state_q != IDLE);
  assign mem_wr     = wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_size   = size_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a latency-accurate memory model.
// Expected responses are queued when requests are driven and checked as rvalid pulses arrive.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  typedef struct packed {
    logic        lsu;
    logic        store;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, lsu_req, lsu_wr;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata;
  logic [2:0]  lsu_size;
  logic        ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_wr, busy;
  logic [2:0]  mem_size;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] rd_pipe [0:LAT-1];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt), .ifu_rvalid(ifu_rvalid),
    .lsu_req(lsu_req), .lsu_wr(lsu_wr), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_size(lsu_size), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E37_79B9) ^ 32'hC001_D00D;
  endfunction

  // Memory model: data for a mem_en cycle is presented exactly LAT cycles later
  always @(posedge clk) begin
    rd_pipe[0] <= mem_en ? mem_read(mem_addr) : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Scoreboard: every rvalid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (ifu_gnt || lsu_gnt) begin
      checks++;
      if ((ifu_gnt && lsu_gnt) !== 1'b0) begin errors++; $display("[TB] FAIL gnt_exclusive: got both gnt high, expected one"); end
    end
    if (ifu_rvalid || lsu_rvalid) begin
      checks++;
      if (ifu_rvalid && lsu_rvalid) begin
        errors++; $display("[TB] FAIL rvalid_exclusive: got both rvalid high, expected one");
      end else if (sb_q.size() == 0) begin
        errors++; $display("[TB] FAIL unexpected_rvalid: got ifu=%b lsu=%b, expected none", ifu_rvalid, lsu_rvalid);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (lsu_rvalid !== e.lsu) begin
          errors++; $display("[TB] FAIL rvalid_owner: got lsu=%b, expected lsu=%b", lsu_rvalid, e.lsu);
        end else if (!e.store && rdata !== e.data) begin
          errors++; $display("[TB] FAIL rdata: got %h, expected %h", rdata, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    ifu_req = 0; lsu_req = 0; lsu_wr = 0;
    ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_size = 3'b010;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, mem_en, mem_wr} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0000000", {busy, ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, mem_en, mem_wr});
    end
    checks++;
    if ({mem_addr, mem_wdata, rdata} !== 96'h0) begin
      errors++; $display("[TB] FAIL reset_data: got addr=%h wdata=%h rdata=%h expected all 0", mem_addr, mem_wdata, rdata);
    end
    checks++;
    if (mem_size !== 3'b010) begin errors++; $display("[TB] FAIL reset_size: got %b expected 010", mem_size); end
    rst = 1'b0;
  endtask

  task automatic test_lsu_store();
    lsu_req = 1; lsu_wr = 1; lsu_addr = 32'h20; lsu_wdata = 32'h1234_5678; lsu_size = 3'b000;
    sb_q.push_back(exp_t'{1'b1, 1'b1, 32'h0});
    @(negedge clk);
    checks++;
    if ({lsu_gnt, ifu_gnt, mem_en, mem_wr} !== 4'b1011) begin
      errors++; $display("[TB] FAIL store_issue: got gnt/ignt/en/wr=%b expected 1011", {lsu_gnt, ifu_gnt, mem_en, mem_wr});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_size} !== {32'h20, 32'h1234_5678, 3'b000}) begin
      errors++; $display("[TB] FAIL store_bus: got %h/%h/%b expected 00000020/12345678/000", mem_addr, mem_wdata, mem_size);
    end
    lsu_req = 0; lsu_addr = 32'hFFF0; lsu_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if ({mem_en, lsu_gnt, mem_wdata} !== {2'b00, 32'h1234_5678}) begin
      errors++; $display("[TB] FAIL store_hold: got en=%b gnt=%b wdata=%h expected 0/0/12345678", mem_en, lsu_gnt, mem_wdata);
    end
    repeat (LAT) @(negedge clk);
    checks++;
    if (lsu_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL store_ack: got %b expected 1", lsu_rvalid); end
    @(negedge clk);
    checks++;
    if ({lsu_rvalid, busy} !== 2'b00) begin errors++; $display("[TB] FAIL store_done: got rvalid/busy=%b expected 00", {lsu_rvalid, busy}); end
  endtask

  task automatic test_ifu_read();
    mem_model[32'h10] = 32'hDEAD_BEEF;
    ifu_req = 1; ifu_addr = 32'h10;
    sb_q.push_back(exp_t'{1'b0, 1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    checks++;
    if ({ifu_gnt, lsu_gnt, mem_en, mem_wr, mem_size} !== 7'b1010_010) begin
      errors++; $display("[TB] FAIL ifu_issue: got gnt/lgnt/en/wr/size=%b expected 1010010", {ifu_gnt, lsu_gnt, mem_en, mem_wr, mem_size});
    end
    ifu_req = 0; ifu_addr = 32'h999;
    @(negedge clk);
    checks++;
    if ({ifu_gnt, mem_en, mem_addr} !== {2'b00, 32'h10}) begin
      errors++; $display("[TB] FAIL ifu_wait: got gnt=%b en=%b addr=%h expected 0/0/00000010", ifu_gnt, mem_en, mem_addr);
    end
    repeat (LAT) @(negedge clk);
    checks++;
    if ({ifu_rvalid, rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("[TB] FAIL ifu_resp: got rvalid=%b rdata=%h expected 1/deadbeef", ifu_rvalid, rdata);
    end
    @(negedge clk);
    checks++;
    if ({ifu_rvalid, busy, rdata} !== {2'b00, 32'hDEAD_BEEF}) begin
      errors++; $display("[TB] FAIL ifu_after: got rvalid=%b busy=%b rdata=%h expected 0/0/deadbeef", ifu_rvalid, busy, rdata);
    end
  endtask

  task automatic test_collision();
    lsu_req = 1; lsu_wr = 0; lsu_addr = 32'h40; lsu_size = 3'b010;
    ifu_req = 1; ifu_addr = 32'h44;
    sb_q.push_back(exp_t'{1'b1, 1'b0, mem_read(32'h40)});
    sb_q.push_back(exp_t'{1'b0, 1'b0, mem_read(32'h44)});
    @(negedge clk);
    checks++;
    if ({lsu_gnt, ifu_gnt, mem_addr} !== {2'b10, 32'h40}) begin
      errors++; $display("[TB] FAIL coll_first: got lgnt=%b ignt=%b addr=%h expected 1/0/00000040", lsu_gnt, ifu_gnt, mem_addr);
    end
    lsu_req = 0;
    repeat (LAT + 1) @(negedge clk);
    checks++;
    if ({lsu_rvalid, ifu_gnt} !== 2'b10) begin
      errors++; $display("[TB] FAIL coll_resp: got lrvalid=%b ignt=%b expected 1/0", lsu_rvalid, ifu_gnt);
    end
    @(negedge clk);
    checks++;
    if ({ifu_gnt, lsu_gnt, mem_addr} !== {2'b10, 32'h44}) begin
      errors++; $display("[TB] FAIL coll_second: got ignt=%b lgnt=%b addr=%h expected 1/0/00000044", ifu_gnt, lsu_gnt, mem_addr);
    end
    ifu_req = 0;
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL coll_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_rr_alternate();
    logic exp_lsu [4];
    lsu_req = 1; lsu_wr = 0; lsu_addr = 32'h80;
    ifu_req = 1; ifu_addr = 32'h84;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_lsu[i] = (i % 2 == 0);
`else
      exp_lsu[i] = 1'b1;
`endif
      sb_q.push_back(exp_t'{exp_lsu[i], 1'b0, mem_read(exp_lsu[i] ? 32'h80 : 32'h84)});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({lsu_gnt, ifu_gnt} !== {exp_lsu[i], !exp_lsu[i]}) begin
        errors++; $display("[TB] FAIL rr_grant%0d: got lgnt=%b ignt=%b expected lgnt=%b", i, lsu_gnt, ifu_gnt, exp_lsu[i]);
      end
      if (i == 3) begin lsu_req = 0; ifu_req = 0; end
      repeat (LAT + 1) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_withdrawn();
    int n_en = 0;
    int n_ign = 0;
    lsu_req = 1; lsu_wr = 0; lsu_addr = 32'h300;
    sb_q.push_back(exp_t'{1'b1, 1'b0, mem_read(32'h300)});
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clk);
      if (mem_en) n_en++;
      if (ifu_gnt) n_ign++;
      if (c == 0) lsu_req = 0;
      if (c == 1) begin ifu_req = 1; ifu_addr = 32'h310; end
      if (c == 2) ifu_req = 0;
    end
    checks++;
    if (n_en !== 1) begin errors++; $display("[TB] FAIL withdrawn_en: got %0d mem_en pulses expected 1", n_en); end
    checks++;
    if (n_ign !== 0) begin errors++; $display("[TB] FAIL withdrawn_gnt: got %0d ifu_gnt pulses expected 0", n_ign); end
  endtask

  task automatic test_reset_mid();
    int n_rv = 0;
    ifu_req = 1; ifu_addr = 32'h400;
    sb_q.push_back(exp_t'{1'b0, 1'b0, mem_read(32'h400)});
    @(negedge clk);
    ifu_req = 0;
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    #1;
    checks++;
    if ({busy, ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, mem_en, mem_wr} !== 7'b0) begin
      errors++; $display("[TB] FAIL rstmid_ctrl: got %b expected 0000000", {busy, ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, mem_en, mem_wr});
    end
    checks++;
    if ({mem_addr, mem_wdata, rdata, mem_size} !== {96'h0, 3'b010}) begin
      errors++; $display("[TB] FAIL rstmid_data: got %h/%h/%h/%b expected 0/0/0/010", mem_addr, mem_wdata, rdata, mem_size);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      if (ifu_rvalid || lsu_rvalid) n_rv++;
    end
    checks++;
    if (n_rv !== 0) begin errors++; $display("[TB] FAIL rstmid_norvalid: got %0d rvalid pulses expected 0", n_rv); end
    ifu_req = 1; ifu_addr = 32'h410;
    sb_q.push_back(exp_t'{1'b0, 1'b0, mem_read(32'h410)});
    @(negedge clk);
    checks++;
    if ({ifu_gnt, mem_en, mem_addr} !== {2'b11, 32'h410}) begin
      errors++; $display("[TB] FAIL rstmid_next: got gnt=%b en=%b addr=%h expected 1/1/00000410", ifu_gnt, mem_en, mem_addr);
    end
    ifu_req = 0;
    repeat (LAT + 1) @(negedge clk);
    checks++;
    if (ifu_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_resp: got %b expected 1", ifu_rvalid); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n_en = 0;
    int n_gnt = 0;
    int last_en = -1;
    lsu_req = 1; lsu_wr = 0; lsu_addr = 32'h500;
    for (int i = 0; i < 3; i++) sb_q.push_back(exp_t'{1'b1, 1'b0, mem_read(32'h500 + 32'(4 * i))});
    for (int c = 0; c < 4 * (LAT + 2) + 4; c++) begin
      @(negedge clk);
      if (mem_en) begin
        if (last_en >= 0) begin
          checks++;
          if (c - last_en !== LAT + 2) begin
            errors++; $display("[TB] FAIL b2b_spacing: got %0d cycles expected %0d", c - last_en, LAT + 2);
          end
        end
        checks++;
        if (mem_addr !== 32'h500 + 32'(4 * n_en)) begin
          errors++; $display("[TB] FAIL b2b_addr: got %h expected %h", mem_addr, 32'h500 + 32'(4 * n_en));
        end
        last_en = c;
        n_en++;
      end
      if (lsu_gnt) begin
        n_gnt++;
        lsu_addr = 32'h500 + 32'(4 * n_gnt);
        if (n_gnt == 3) lsu_req = 0;
      end
    end
    checks++;
    if (n_en !== 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d accesses expected 3", n_en); end
  endtask

  initial begin
    test_reset();
    test_lsu_store();
    test_ifu_read();
    test_collision();
    test_rr_alternate();
    test_withdrawn();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("[TB] FAIL sb_drained: got %0d outstanding expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
